// File: rtl/adc_scan_ctrl.sv
// AD7928-style SPI ADC sequencer: power-up frames, round-robin channel scan, channel-tagged results.
// Frame is 33*CLK_DIV cycles; result posted the cycle ADCss rises; there is no downstream backpressure.
module adc_scan_ctrl #(
   parameter int unsigned CLK_DIV      = 2,
   parameter int unsigned QUIET_CYCLES = 4,
   parameter bit          RANGE_BIT    = 1'b0,
   parameter bit          CODING_BIT   = 1'b1
) (
   input  logic        SysClock,
   input  logic        nReset,
   input  logic        Enable,
   input  logic [7:0]  ChanMask,
   input  logic        ADC_Dout,
   output logic        SPIClock,
   output logic        ADCss,
   output logic        ADC_Din,
   output logic [11:0] ResultData,
   output logic [2:0]  ResultChan,
   output logic        ResultValid,
   output logic        Busy
);

   typedef enum logic [2:0] {
      S_PWRUP_PEND,
      S_PWRUP,
      S_IDLE,
      S_FRAME,
      S_QUIET
   } state_t;

   localparam logic [7:0]      DIV_LAST = 8'(CLK_DIV - 1);
   localparam int unsigned     QW       = $clog2(QUIET_CYCLES + 1);
   localparam logic [QW-1:0]   Q_LAST   = QW'(QUIET_CYCLES - 1);

   state_t        state_q, state_d;
   logic [7:0]    div_q, div_d;
   logic [5:0]    ph_q, ph_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    pwr_q, pwr_d;
   logic [2:0]    add_q, add_d;
   logic [15:0]   tx_q, tx_d;
   logic [14:0]   rx_q, rx_d;
   logic          pend_q, pend_d;
   logic          sclk_q, sclk_d;
   logic          ss_q, ss_d;
   logic          rv_q, rv_d;
   logic [11:0]   rdata_q, rdata_d;
   logic [2:0]    rchan_q, rchan_d;
   logic          busy_q, busy_d;

   logic          scan_ok;
   logic          start_scan;
   logic          start_pwr;
   logic          in_frame_d;
   logic [2:0]    chan_nx;

   function automatic logic [15:0] ctrl_word(input logic [2:0] add);
      return {1'b1, 2'b00, add, 2'b11, 2'b00, RANGE_BIT, CODING_BIT, 4'b0000};
   endfunction

   // Search offsets 7..1 so the smallest offset wins; offset 8 (same channel) is the default.
   function automatic logic [2:0] next_chan(input logic [2:0] prev, input logic [7:0] mask);
      logic [2:0] c;
      logic [2:0] sel;
      sel = prev;
      for (int i = 7; i >= 1; i--) begin
         c = prev + 3'(i);
         if (mask[c]) sel = c;
      end
      return sel;
   endfunction

   assign scan_ok = Enable && (ChanMask != 8'h00);
   assign chan_nx = next_chan(add_q, ChanMask);

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      ph_d       = ph_q;
      qcnt_d     = qcnt_q;
      pwr_d      = pwr_q;
      add_d      = add_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      pend_d     = pend_q;
      rv_d       = 1'b0;
      rdata_d    = rdata_q;
      rchan_d    = rchan_q;
      start_scan = 1'b0;
      start_pwr  = 1'b0;

      case (state_q)
         S_PWRUP_PEND: begin
            if (scan_ok) start_pwr = 1'b1;
         end
         S_IDLE: begin
            if (scan_ok) begin
               start_scan = 1'b1;
            end else if (!Enable) begin
               pend_d = 1'b0;
            end
         end
         S_PWRUP, S_FRAME: begin
            if (div_q == DIV_LAST) begin
               div_d = 8'd0;
               if (ph_q == 6'd32) begin
                  state_d = S_QUIET;
                  qcnt_d  = '0;
                  ph_d    = 6'd0;
                  if (state_q == S_PWRUP) begin
                     pwr_d  = pwr_q + 2'd1;
                     pend_d = 1'b0;
                  end else begin
                     rv_d   = pend_q;
                     pend_d = 1'b1;
                     if (pend_q) begin
                        rdata_d = rx_q[11:0];
                        rchan_d = rx_q[14:12];
                     end
                  end
               end else begin
                  ph_d = ph_q + 6'd1;
                  // Odd phase ending means SPIClock rises: launch next Din bit, sample Dout.
                  if (ph_q[0]) begin
                     tx_d = {tx_q[14:0], 1'b0};
                     rx_d = {rx_q[13:0], ADC_Dout};
                  end
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         S_QUIET: begin
            if (qcnt_q == Q_LAST) begin
               if (pwr_q < 2'd2) begin
                  start_pwr = 1'b1;
               end else if (scan_ok) begin
                  start_scan = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               qcnt_d = qcnt_q + QW'(1);
            end
         end
         default: state_d = S_PWRUP_PEND;
      endcase

      if (start_pwr) begin
         state_d = S_PWRUP;
         div_d   = 8'd0;
         ph_d    = 6'd0;
         tx_d    = 16'hFFFF;
      end
      if (start_scan) begin
         state_d = S_FRAME;
         div_d   = 8'd0;
         ph_d    = 6'd0;
         add_d   = chan_nx;
         tx_d    = ctrl_word(chan_nx);
      end

      in_frame_d = (state_d == S_FRAME) || (state_d == S_PWRUP);
      ss_d       = !in_frame_d;
      sclk_d     = !(in_frame_d && ph_d[0]);
      busy_d     = !((state_d == S_IDLE) || (state_d == S_PWRUP_PEND));
   end

   always_ff @(posedge SysClock or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_PWRUP_PEND;
         div_q   <= 8'd0;
         ph_q    <= 6'd0;
         qcnt_q  <= '0;
         pwr_q   <= 2'd0;
         add_q   <= 3'd7;
         tx_q    <= 16'h0000;
         rx_q    <= 15'h0000;
         pend_q  <= 1'b0;
         sclk_q  <= 1'b1;
         ss_q    <= 1'b1;
         rv_q    <= 1'b0;
         rdata_q <= 12'h000;
         rchan_q <= 3'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ph_q    <= ph_d;
         qcnt_q  <= qcnt_d;
         pwr_q   <= pwr_d;
         add_q   <= add_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         pend_q  <= pend_d;
         sclk_q  <= sclk_d;
         ss_q    <= ss_d;
         rv_q    <= rv_d;
         rdata_q <= rdata_d;
         rchan_q <= rchan_d;
         busy_q  <= busy_d;
      end
   end

   assign SPIClock    = sclk_q;
   assign ADCss       = ss_q;
   assign ADC_Din     = tx_q[15];
   assign ResultData  = rdata_q;
   assign ResultChan  = rchan_q;
   assign ResultValid = rv_q;
   assign Busy        = busy_q;

endmodule
